// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/MEM memory-port arbiter: FSM states, owner,
// access size codes and stall-bus bit positions.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int STALL_IF_BIT  = 0;
  localparam int STALL_MEM_BIT = 1;
  localparam int STALL_W       = 2;

  function automatic logic [3:0] streak_inc_sat(input logic [3:0] cur,
                                                input logic [3:0] lim);
    return (cur >= lim) ? lim : cur + 4'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_prio.sv
// Grant logic for the shared memory port: data wins unless instruction
// fetch has been starved for STARVE_LIM consecutive data grants.
module mem_port_prio
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic flush,
  input  logic inst_req,
  input  logic data_req,
  output logic grant_inst,
  output logic grant_data
);

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  logic [3:0] streak_q, streak_d;

  always_comb begin
    grant_data = arb_en && data_req && !(inst_req && (streak_q == LIM));
    grant_inst = arb_en && !grant_data && inst_req && !flush;
    streak_d   = streak_q;
    if (grant_data && inst_req) begin
      streak_d = streak_inc_sat(streak_q, LIM);
    end else if (grant_inst || grant_data) begin
      streak_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) streak_q <= 4'd0;
    else     streak_q <= streak_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF and MEM requesters onto one SRAM-like port, one transaction
// at a time, with flush cancellation of in-flight fetches and stall requests.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [3:0]        bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              stallreq_if,
  output logic              stallreq_mem
);

  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  logic       cancel_q, cancel_d;

  logic              bus_wr_q, bus_wr_d;
  logic [1:0]        bus_size_q, bus_size_d;
  logic [3:0]        bus_wstrb_q, bus_wstrb_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;

  logic               arb_en, grant_inst, grant_data;
  logic [STALL_W-1:0] stall_bus;

  assign arb_en = (state_q == ST_IDLE) && !rst;

  mem_port_prio #(.STARVE_LIM(STARVE_LIM)) u_prio (
    .clk       (clk),
    .rst       (rst),
    .arb_en    (arb_en),
    .flush     (flush),
    .inst_req  (inst_req),
    .data_req  (data_req),
    .grant_inst(grant_inst),
    .grant_data(grant_data)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cancel_d     = cancel_q;
    bus_wr_d     = bus_wr_q;
    bus_size_d   = bus_size_q;
    bus_wstrb_d  = bus_wstrb_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    bus_req      = 1'b0;
    stall_bus    = '0;

    case (state_q)
      ST_IDLE: begin
        if (grant_data) begin
          owner_d      = OWN_DATA;
          bus_wr_d     = data_wr;
          bus_size_d   = data_size;
          bus_wstrb_d  = data_wstrb;
          bus_addr_d   = data_addr;
          bus_wdata_d  = data_wdata;
          data_addr_ok = 1'b1;
          state_d      = ST_REQ;
        end else if (grant_inst) begin
          owner_d      = OWN_INST;
          cancel_d     = 1'b0;
          bus_wr_d     = 1'b0;
          bus_size_d   = SZ_WORD;
          bus_wstrb_d  = 4'b0000;
          bus_addr_d   = inst_addr;
          inst_addr_ok = 1'b1;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        bus_req = 1'b1;
        if (flush && owner_q == OWN_INST) cancel_d = 1'b1;
        if (bus_addr_ok) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (flush && owner_q == OWN_INST) cancel_d = 1'b1;
        if (bus_data_ok) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_DATA) begin
            data_data_ok = 1'b1;
          end else begin
            // The response of a flushed fetch is consumed but not forwarded.
            inst_data_ok = !cancel_q;
            cancel_d     = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    stall_bus[STALL_IF_BIT]  = inst_req && !inst_data_ok;
    stall_bus[STALL_MEM_BIT] = (data_req || (owner_q == OWN_DATA && state_q != ST_IDLE))
                               && !data_data_ok;

    if (rst) begin
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      data_data_ok = 1'b0;
      bus_req      = 1'b0;
      stall_bus    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_INST;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cancel_q <= cancel_d;
    end
  end

  always_ff @(posedge clk) begin
    bus_wr_q    <= bus_wr_d;
    bus_size_q  <= bus_size_d;
    bus_wstrb_q <= bus_wstrb_d;
    bus_addr_q  <= bus_addr_d;
    bus_wdata_q <= bus_wdata_d;
  end

  assign bus_wr       = bus_wr_q;
  assign bus_size     = bus_size_q;
  assign bus_wstrb    = bus_wstrb_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign inst_rdata   = inst_data_ok ? bus_rdata : '0;
  assign data_rdata   = data_data_ok ? bus_rdata : '0;
  assign stallreq_if  = stall_bus[STALL_IF_BIT];
  assign stallreq_mem = stall_bus[STALL_MEM_BIT];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: expected responses are queued at
// request time and retired by a monitor when the arbiter signals data_ok.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = 2'd2;
  logic [3:0]  data_wstrb = 4'd0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok = 1'b0, bus_data_ok = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        stallreq_if, stallreq_mem;

  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;
  logic [31:0] exp_data[$];
  logic [31:0] exp_inst[$];
  byte         exp_order[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
  );

  // Response scoreboard: every data_ok pulse must match a queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (data_data_ok) begin
        total++;
        if (exp_data.size() == 0) begin
          bad++;
          $display("FAIL data_ok_unexpected: data_data_ok=1 rdata=%h, required no pulse", data_rdata);
        end else begin
          logic [31:0] e;
          e = exp_data.pop_front();
          if (data_rdata !== e) begin
            bad++;
            $display("FAIL data_rdata: got %h, required %h", data_rdata, e);
          end
        end
      end
      if (inst_data_ok) begin
        total++;
        if (exp_inst.size() == 0) begin
          bad++;
          $display("FAIL inst_ok_unexpected: inst_data_ok=1 rdata=%h, required no pulse", inst_rdata);
        end else begin
          logic [31:0] e;
          e = exp_inst.pop_front();
          if (inst_rdata !== e) begin
            bad++;
            $display("FAIL inst_rdata: got %h, required %h", inst_rdata, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    inst_req = 1'b1;
    data_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok,
         stallreq_if, stallreq_mem} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b, required 0000000",
               {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok,
                stallreq_if, stallreq_mem});
    end
    tick();
    rst = 1'b0;
    inst_req = 1'b0;
    data_req = 1'b0;
    mon_en = 1'b1;
    tick();
  endtask

  task automatic test_lone_load();
    int req_cycles = 0;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_0010;
    exp_data.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    total++;
    if (data_addr_ok !== 1'b1 || stallreq_mem !== 1'b1) begin
      bad++;
      $display("FAIL load_grant: addr_ok=%b stall=%b, required 1 1", data_addr_ok, stallreq_mem);
    end
    tick(); data_req = 1'b0;
    @(negedge clk);
    if (bus_req) req_cycles++;
    total++;
    if (bus_addr !== 32'h8000_0010 || bus_wr !== 1'b0 || bus_size !== 2'd2) begin
      bad++;
      $display("FAIL load_fields: addr=%h wr=%b size=%0d, required 80000010 0 2",
               bus_addr, bus_wr, bus_size);
    end
    tick(); bus_addr_ok = 1'b1;
    @(negedge clk);
    if (bus_req) req_cycles++;
    tick(); bus_addr_ok = 1'b0;
    @(negedge clk);
    if (bus_req) req_cycles++;
    total++;
    if (req_cycles != 2) begin
      bad++;
      $display("FAIL load_req_len: got %0d cycles, required 2", req_cycles);
    end
    tick(); bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    total++;
    if (stallreq_mem !== 1'b0) begin
      bad++;
      $display("FAIL load_stall_ok_cycle: got %b, required 0", stallreq_mem);
    end
    tick(); bus_data_ok = 1'b0; bus_rdata = 32'h5555_5555;
    @(negedge clk);
    total++;
    if (stallreq_mem !== 1'b0 || data_rdata !== 32'h0) begin
      bad++;
      $display("FAIL load_after: stall=%b rdata=%h, required 0 00000000", stallreq_mem, data_rdata);
    end
    tick();
  endtask

  task automatic test_store();
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_wstrb = 4'b0100;
    data_wdata = 32'h0000_AB00; data_addr = 32'h1000_0006;
    bus_rdata = 32'h0;
    exp_data.push_back(32'h0);
    @(negedge clk);
    total++;
    if (data_addr_ok !== 1'b1) begin
      bad++;
      $display("FAIL store_grant: got %b, required 1", data_addr_ok);
    end
    tick();
    data_req = 1'b0; data_wdata = 32'hFFFF_FFFF; data_addr = 32'h0; data_wstrb = 4'hF; data_wr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) bus_addr_ok = 1'b1;
      @(negedge clk);
      total++;
      if ({bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata} !==
          {1'b1, 1'b1, 2'd0, 4'b0100, 32'h1000_0006, 32'h0000_AB00}) begin
        bad++;
        $display("FAIL store_hold[%0d]: req=%b wr=%b size=%0d strb=%b addr=%h wdata=%h, required 1 1 0 0100 10000006 0000ab00",
                 i, bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata);
      end
      tick();
    end
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
    tick(); bus_data_ok = 1'b0;
    tick();
  endtask

  task automatic test_flush_fetch();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    @(negedge clk);
    total++;
    if (inst_addr_ok !== 1'b1) begin
      bad++;
      $display("FAIL fetch_grant: got %b, required 1", inst_addr_ok);
    end
    tick(); inst_req = 1'b0; bus_addr_ok = 1'b1;
    @(negedge clk);
    total++;
    if ({bus_req, bus_wr, bus_size, bus_wstrb, bus_addr} !== {1'b1, 1'b0, 2'd2, 4'b0, 32'hBFC0_0000}) begin
      bad++;
      $display("FAIL fetch_fields: req=%b wr=%b size=%0d strb=%b addr=%h, required 1 0 2 0000 bfc00000",
               bus_req, bus_wr, bus_size, bus_wstrb, bus_addr);
    end
    tick(); bus_addr_ok = 1'b0; flush = 1'b1;
    tick(); flush = 1'b0;
    tick();
    tick(); bus_data_ok = 1'b1; bus_rdata = 32'h1111_1111;
    @(negedge clk);
    total++;
    if (inst_data_ok !== 1'b0 || inst_rdata !== 32'h0) begin
      bad++;
      $display("FAIL flushed_drop: ok=%b rdata=%h, required 0 00000000", inst_data_ok, inst_rdata);
    end
    tick(); bus_data_ok = 1'b0;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    exp_inst.push_back(32'h2222_2222);
    @(negedge clk);
    total++;
    if (inst_addr_ok !== 1'b1) begin
      bad++;
      $display("FAIL refetch_grant: got %b, required 1", inst_addr_ok);
    end
    tick(); inst_req = 1'b0; bus_addr_ok = 1'b1;
    tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h2222_2222;
    tick(); bus_data_ok = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_0100;
    tick(); data_req = 1'b0; bus_addr_ok = 1'b1;
    tick(); bus_addr_ok = 1'b0;
    rst = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h7777_7777;
    @(negedge clk);
    total++;
    if ({bus_req, inst_data_ok, data_data_ok, stallreq_if, stallreq_mem, data_rdata} !== 37'b0) begin
      bad++;
      $display("FAIL reset_mid: req=%b iok=%b dok=%b sif=%b smem=%b rdata=%h, required all 0",
               bus_req, inst_data_ok, data_data_ok, stallreq_if, stallreq_mem, data_rdata);
    end
    tick(); rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus_req, data_data_ok, inst_data_ok, stallreq_mem} !== 4'b0) begin
      bad++;
      $display("FAIL stray_ok: req=%b dok=%b iok=%b smem=%b, required 0 0 0 0",
               bus_req, data_data_ok, inst_data_ok, stallreq_mem);
    end
    tick(); bus_data_ok = 1'b0;
    @(negedge clk);
    total++;
    if (bus_req !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: bus_req=%b, required 0", bus_req);
    end
    tick();
  endtask

  task automatic test_flush_idle();
    inst_req = 1'b1; flush = 1'b1; inst_addr = 32'hBFC0_0008;
    @(negedge clk);
    total++;
    if (inst_addr_ok !== 1'b0 || stallreq_if !== 1'b1) begin
      bad++;
      $display("FAIL flush_idle_block: addr_ok=%b stall=%b, required 0 1", inst_addr_ok, stallreq_if);
    end
    tick(); flush = 1'b0;
    exp_inst.push_back(32'h3333_3333);
    @(negedge clk);
    total++;
    if (inst_addr_ok !== 1'b1) begin
      bad++;
      $display("FAIL flush_idle_next: addr_ok=%b, required 1", inst_addr_ok);
    end
    tick(); inst_req = 1'b0; bus_addr_ok = 1'b1;
    tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h3333_3333;
    tick(); bus_data_ok = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    string order = "DDDDIDDDDI";
    int n = 0;
    int peak = 0;
    for (int i = 0; i < order.len(); i++) begin
      exp_order.push_back(order[i]);
      if (order[i] == "D") exp_data.push_back(32'hCAFE_F00D);
      else                 exp_inst.push_back(32'hCAFE_F00D);
    end
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
    data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_0200; inst_addr = 32'hBFC0_0100;
    inst_req = 1'b1; data_req = 1'b1;
    for (int c = 0; c < 80 && n < 10; c++) begin
      @(negedge clk);
      if (int'(dut.u_prio.streak_q) > peak) peak = int'(dut.u_prio.streak_q);
      if (inst_addr_ok || data_addr_ok) begin
        byte got, want;
        got  = data_addr_ok ? "D" : "I";
        want = exp_order.pop_front();
        total++;
        if (got != want) begin
          bad++;
          $display("FAIL grant_order[%0d]: got %c, required %c", n, got, want);
        end
        n++;
      end
      if (n < 10) tick();
    end
    tick(); inst_req = 1'b0; data_req = 1'b0;
    repeat (4) tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    tick();
    total++;
    if (n != 10) begin
      bad++;
      $display("FAIL contention_timeout: got %0d grants, required 10", n);
    end
    total++;
    if (peak != 4) begin
      bad++;
      $display("FAIL streak_peak: got %0d, required 4", peak);
    end
  endtask

  initial begin
    test_reset();
    test_lone_load();
    test_store();
    test_flush_fetch();
    test_reset_mid();
    test_flush_idle();
    test_contention();
    repeat (2) tick();
    total++;
    if (exp_data.size() != 0 || exp_inst.size() != 0) begin
      bad++;
      $display("FAIL responses_missing: data=%0d inst=%0d left, required 0 0",
               exp_data.size(), exp_inst.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
